// File: rtl/top_link_if.sv
// Parallel-side bundle of the serial link endpoint: transmit handshake plus receive results.
interface top_link_if #(
  parameter int width_p = 8
);
  logic [width_p-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [width_p-1:0] rx_data;
  logic               rx_valid;
  logic               rx_err;

  modport master (output tx_data, output tx_valid, input tx_ready,
                  input rx_data, input rx_valid, input rx_err);
  modport slave  (input tx_data, input tx_valid, output tx_ready,
                  output rx_data, output rx_valid, output rx_err);
endinterface

// File: rtl/top_link.sv
// UART-style serial link endpoint: start bit, width_p data bits LSB first, stop bit,
// with div_p clocks per bit. Transmitter and receiver run independently.
module top_link #(
  parameter int width_p = 8,
  parameter int div_p   = 16
) (
  input  logic       main_clk_i,
  input  logic       main_rst_an_i,
  top_link_if.slave  bus_io,
  output logic       intf_tx_o,
  input  logic       intf_rx_i
);

  localparam int CntW = $clog2(div_p);
  localparam int BitW = $clog2(width_p + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(div_p - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(div_p / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(width_p - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} linkState_t;

  linkState_t         txState_q;
  logic [CntW-1:0]    txCnt_q;
  logic [BitW-1:0]    txBit_q;
  logic [width_p-1:0] txShift_q;
  logic [width_p-1:0] txShiftNext;
  logic               txLine_q;
  logic               txReady_q;

  linkState_t         rxState_q;
  logic [CntW-1:0]    rxCnt_q;
  logic [BitW-1:0]    rxBit_q;
  logic [width_p-1:0] rxShift_q;
  logic [width_p-1:0] rxData_q;
  logic               rxValid_q;
  logic               rxErr_q;
  logic               sync1_q;
  logic               sync2_q;
  logic               rxPrev_q;

  assign txShiftNext     = txShift_q >> 1;
  assign intf_tx_o       = txLine_q;
  assign bus_io.tx_ready = txReady_q;
  assign bus_io.rx_data  = rxData_q;
  assign bus_io.rx_valid = rxValid_q;
  assign bus_io.rx_err   = rxErr_q;

  // The line level is registered so the handshake edge is also the start-bit edge.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      txState_q <= IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txLine_q  <= 1'b1;
      txReady_q <= 1'b1;
    end else begin
      case (txState_q)
        IDLE: begin
          if (bus_io.tx_valid && txReady_q) begin
            txShift_q <= bus_io.tx_data;
            txLine_q  <= 1'b0;
            txReady_q <= 1'b0;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txState_q <= START;
          end
        end
        START: begin
          if (txCnt_q == CntLast) begin
            txCnt_q   <= '0;
            txLine_q  <= txShift_q[0];
            txState_q <= DATA;
          end else begin
            txCnt_q <= txCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (txCnt_q == CntLast) begin
            txCnt_q   <= '0;
            txShift_q <= txShiftNext;
            if (txBit_q == BitLast) begin
              txLine_q  <= 1'b1;
              txState_q <= STOP;
            end else begin
              txBit_q  <= txBit_q + 1'b1;
              txLine_q <= txShiftNext[0];
            end
          end else begin
            txCnt_q <= txCnt_q + 1'b1;
          end
        end
        STOP: begin
          if (txCnt_q == CntLast) begin
            txCnt_q   <= '0;
            txReady_q <= 1'b1;
            txState_q <= IDLE;
          end else begin
            txCnt_q <= txCnt_q + 1'b1;
          end
        end
        default: txState_q <= IDLE;
      endcase
    end
  end

  // Synchroniser plus one history flop for falling-edge detection; idle level is high.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= intf_rx_i;
      sync2_q  <= sync1_q;
      rxPrev_q <= sync2_q;
    end
  end

  // Requiring a fresh falling edge means a line stuck low after an error stays silent.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      rxState_q <= IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      rxErr_q   <= 1'b0;
    end else begin
      rxValid_q <= 1'b0;
      rxErr_q   <= 1'b0;
      case (rxState_q)
        IDLE: begin
          if (rxPrev_q && !sync2_q) begin
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxState_q <= START;
          end
        end
        START: begin
          if (rxCnt_q == CntHalf) begin
            rxCnt_q   <= '0;
            rxState_q <= sync2_q ? IDLE : DATA;
          end else begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (rxCnt_q == CntLast) begin
            rxCnt_q   <= '0;
            rxShift_q <= (rxShift_q >> 1) | (width_p'(sync2_q) << (width_p - 1));
            if (rxBit_q == BitLast) begin
              rxState_q <= STOP;
            end else begin
              rxBit_q <= rxBit_q + 1'b1;
            end
          end else begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end
        end
        STOP: begin
          if (rxCnt_q == CntLast) begin
            rxCnt_q   <= '0;
            rxState_q <= IDLE;
            if (sync2_q) begin
              rxData_q  <= rxShift_q;
              rxValid_q <= 1'b1;
            end else begin
              rxErr_q <= 1'b1;
            end
          end else begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end
        end
        default: rxState_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_link.sv
// Self-checking bench for top_link: directed frames plus randomized loopback traffic
// compared against a frame-level reference model.
module tb_top_link;
  localparam int WIDTH = 8;
  localparam int DIV   = 16;
  localparam int FRAME = (WIDTH + 2) * DIV;
  localparam int NRAND = 12;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic benchRx = 1'b1;
  logic loopMode = 1'b0;
  logic intfTx;
  logic intfRx;

  int checks = 0;
  int passes = 0;
  int errCount = 0;
  logic [WIDTH-1:0] rxQ[$];

  top_link_if #(.width_p(WIDTH)) bus ();

  top_link #(.width_p(WIDTH), .div_p(DIV)) dut (
    .main_clk_i   (clk),
    .main_rst_an_i(rstN),
    .bus_io       (bus.slave),
    .intf_tx_o    (intfTx),
    .intf_rx_i    (intfRx)
  );

  assign intfRx = loopMode ? intfTx : benchRx;

  always #5 clk = ~clk;

  // Receive-side monitor: every valid pulse is queued, every error pulse counted.
  always @(negedge clk) begin
    if (rstN) begin
      if (bus.rx_valid) rxQ.push_back(bus.rx_data);
      if (bus.rx_err) errCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Offers a word on the transmit handshake and returns half a cycle after it is taken.
  task automatic applyStimulus(input logic [WIDTH-1:0] word);
    int n = 0;
    bus.tx_data  = word;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) checkOutput("tx handshake timeout", 32'(n), 32'(2 * FRAME - 1));
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = WIDTH'($urandom);
  endtask

  function automatic logic frameLevel(input logic [WIDTH-1:0] word, input logic stopLevel, input int j);
    if (j == 0) return 1'b0;
    if (j <= WIDTH) return word[j-1];
    return stopLevel;
  endfunction

  task automatic driveRxFrame(input logic [WIDTH-1:0] word, input logic stopLevel);
    for (int j = 0; j < WIDTH + 2; j++) begin
      benchRx = frameLevel(word, stopLevel, j);
      repeat (DIV) @(negedge clk);
    end
    benchRx = 1'b1;
  endtask

  task automatic waitRx(input int target, input int budget);
    int n = 0;
    while (rxQ.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int match[WIDTH+2];
    int readyLow;
    int errBase;
    int cyc;
    int lastHs;
    int gap;
    int sent;
    int readyBad;
    logic expectReady;
    logic [WIDTH-1:0] expQ[$];
    logic [WIDTH-1:0] words[3];

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;

    // Reset
    repeat (4) @(negedge clk);
    checkOutput("reset tx line", 32'(intfTx), 32'd1);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset tx line after release", 32'(intfTx), 32'd1);
    checkOutput("reset tx ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("reset rx valid", 32'(bus.rx_valid), 32'd0);
    checkOutput("reset rx err", 32'(bus.rx_err), 32'd0);
    checkOutput("reset rx data", 32'(bus.rx_data), 32'd0);

    // Single TX frame, per-cycle line shape and ready window
    applyStimulus(8'hA5);
    readyLow = 0;
    for (int j = 0; j < WIDTH + 2; j++) match[j] = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (intfTx === frameLevel(8'hA5, 1'b1, c / DIV)) match[c / DIV]++;
      if (!bus.tx_ready) readyLow++;
      @(negedge clk);
    end
    for (int j = 0; j < WIDTH + 2; j++)
      checkOutput($sformatf("tx A5 bit slot %0d", j), 32'(match[j]), 32'(DIV));
    checkOutput("tx ready low cycles", 32'(readyLow), 32'(FRAME));
    checkOutput("tx ready after frame", 32'(bus.tx_ready), 32'd1);
    repeat (4) @(negedge clk);

    // Loopback, back-to-back with valid held high
    loopMode = 1'b1;
    rxQ.delete();
    errBase = errCount;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
    for (int w = 0; w < 3; w++) begin
      int n = 0;
      bus.tx_data  = words[w];
      bus.tx_valid = 1'b1;
      while (!bus.tx_ready && n < 2 * FRAME) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    waitRx(3, 3 * FRAME);
    checkOutput("b2b rx count", 32'(rxQ.size()), 32'd3);
    for (int w = 0; w < 3; w++)
      checkOutput($sformatf("b2b rx word %0d", w), (w < rxQ.size()) ? 32'(rxQ[w]) : 32'hDEAD, 32'(words[w]));
    checkOutput("b2b rx err count", 32'(errCount - errBase), 32'd0);
    repeat (2 * DIV) @(negedge clk);

    // False start, then a good frame
    loopMode = 1'b0;
    rxQ.delete();
    errBase = errCount;
    benchRx = 1'b0;
    repeat (5) @(negedge clk);
    benchRx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    checkOutput("false start rx count", 32'(rxQ.size()), 32'd0);
    checkOutput("false start err count", 32'(errCount - errBase), 32'd0);
    driveRxFrame(8'h5A, 1'b1);
    waitRx(1, 2 * DIV);
    checkOutput("after false start rx count", 32'(rxQ.size()), 32'd1);
    checkOutput("after false start rx word", (rxQ.size() > 0) ? 32'(rxQ[0]) : 32'hDEAD, 32'h5A);

    // Framing error, line held low through the stop bit
    rxQ.delete();
    errBase = errCount;
    driveRxFrame(8'h81, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    checkOutput("framing err count", 32'(errCount - errBase), 32'd1);
    checkOutput("framing err rx count", 32'(rxQ.size()), 32'd0);
    checkOutput("framing err rx data kept", 32'(bus.rx_data), 32'h5A);
    driveRxFrame(8'h42, 1'b1);
    waitRx(1, 2 * DIV);
    checkOutput("after framing err rx word", (rxQ.size() > 0) ? 32'(rxQ[0]) : 32'hDEAD, 32'h42);
    checkOutput("after framing err err count", 32'(errCount - errBase), 32'd1);

    // Randomized loopback traffic against a frame-level model
    loopMode = 1'b1;
    rxQ.delete();
    expQ.delete();
    errBase = errCount;
    cyc = 0; lastHs = -FRAME; gap = 0; sent = 0; readyBad = 0;
    while (sent < NRAND && cyc < 40000) begin
      expectReady = (cyc - lastHs) >= FRAME;
      if (bus.tx_ready !== expectReady) readyBad++;
      if (expectReady && gap > 0) begin
        bus.tx_valid = 1'b0;
        gap--;
      end else if (expectReady) begin
        bus.tx_valid = 1'b1;
      end else begin
        bus.tx_valid = 1'($urandom_range(0, 1));
      end
      bus.tx_data = WIDTH'($urandom);
      if (bus.tx_valid && expectReady) begin
        expQ.push_back(bus.tx_data);
        lastHs = cyc + 1;
        sent++;
        gap = $urandom_range(0, 20);
      end
      @(negedge clk);
      cyc++;
    end
    bus.tx_valid = 1'b0;
    waitRx(expQ.size(), 3 * FRAME);
    checkOutput("rand ready timing errors", 32'(readyBad), 32'd0);
    checkOutput("rand rx count", 32'(rxQ.size()), 32'(NRAND));
    for (int i = 0; i < expQ.size(); i++)
      checkOutput($sformatf("rand rx word %0d", i), (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hDEAD, 32'(expQ[i]));
    checkOutput("rand rx err count", 32'(errCount - errBase), 32'd0);
    repeat (2 * DIV) @(negedge clk);

    // Reset during TX bit 3 and RX bit 4
    loopMode = 1'b0;
    rxQ.delete();
    errBase = errCount;
    for (int c = 0; c < 85; c++) begin
      benchRx = frameLevel(8'h00, 1'b1, c / DIV);
      if (c == 12) begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
      end
      if (c == 13) bus.tx_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("mid-frame tx line before reset", 32'(intfTx), 32'd0);
    rstN = 1'b0;
    benchRx = 1'b1;
    #1;
    checkOutput("mid-frame tx line in reset", 32'(intfTx), 32'd1);
    checkOutput("mid-frame tx ready in reset", 32'(bus.tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    checkOutput("mid-frame rx count", 32'(rxQ.size()), 32'd0);
    checkOutput("mid-frame err count", 32'(errCount - errBase), 32'd0);
    loopMode = 1'b1;
    applyStimulus(8'hC3);
    waitRx(1, 2 * FRAME);
    checkOutput("recovery rx word", (rxQ.size() > 0) ? 32'(rxQ[0]) : 32'hDEAD, 32'hC3);
    checkOutput("recovery err count", 32'(errCount - errBase), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
